bsg_downstream_io_wr: RTL and testbench

BSG_DOWNSTREAM_IO_WR -- requirements
Module: bsg_downstream_io_wr

---
 rtl/bsg_ds_pkg.sv | 16 +
 rtl/bsg_ds_byte_pair.sv | 58 +++++
 rtl/bsg_downstream_io_wr.sv | 128 ++++++++++++
 tb/tb_bsg_downstream_io_wr.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/bsg_ds_pkg.sv
// Shared defaults, pointer type and byte-pairing state encoding for the
// downstream io write path.
package bsg_ds_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int WORD_W_DEF = 16;

  // Write/read pointer: address field plus one wrap bit.
  typedef logic [ADDR_W_DEF:0] ptr_t;

  typedef enum logic [0:0] {
    LO = 1'b0,
    HI = 1'b1
  } pair_state_e;

endpackage

// File: rtl/bsg_ds_byte_pair.sv
// Pairs consecutive io bytes (low byte first) into a 16-bit word; a low byte
// arriving while blocked is dropped and flagged.
module bsg_ds_byte_pair
  import bsg_ds_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [7:0]  byte_i,
  input  logic        block_i,
  output logic [15:0] word_o,
  output logic        word_valid_o,
  output logic        drop_o
);

  pair_state_e state_q, state_d;
  logic [7:0]  lo_q, lo_d;

  // Next-state and low-byte latch; a started word always completes in HI.
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    case (state_q)
      LO: begin
        if (valid_i && !block_i) begin
          lo_d    = byte_i;
          state_d = HI;
        end else begin
          state_d = LO;
        end
      end
      HI: begin
        if (valid_i) begin
          state_d = LO;
        end else begin
          state_d = HI;
        end
      end
      default: state_d = LO;
    endcase
  end

  // Pairing state and latched low byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LO;
      lo_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
    end
  end

  assign word_o       = {byte_i, lo_q};
  assign word_valid_o = (state_q == HI) && valid_i;
  assign drop_o       = (state_q == LO) && valid_i && block_i;

endmodule

// File: rtl/bsg_downstream_io_wr.sv
// Write side of the downstream io buffer: registers io bytes, pairs them into
// words, writes the buffer and publishes the write pointer one cycle late.
// Optional dropped-byte counter: define BSG_DS_IO_WR_OVF_CNT_EN.
module bsg_downstream_io_wr
  import bsg_ds_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              io_valid_in,
  input  logic [7:0]        io_data_in,
  input  logic [ADDR_W:0]   rptr_in,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_waddr,
  output logic [WORD_W-1:0] buf_wdata,
  output logic [ADDR_W:0]   wptr,
  output logic [ADDR_W:0]   wptr_t,
  output logic              full,
  output logic              io_valid,
  output logic [7:0]        io_data,
  output logic              overflow
`ifdef BSG_DS_IO_WR_OVF_CNT_EN
  , output logic [7:0]      ovf_cnt
`endif
);

  logic              io_valid_q;
  logic [7:0]        io_data_q;
  logic [ADDR_W:0]   wptr_q, wptr_d;
  logic [ADDR_W:0]   wptr_t_q, wptr_t_d;
  logic              buf_we_q, buf_we_d;
  logic [ADDR_W-1:0] buf_waddr_q, buf_waddr_d;
  logic [WORD_W-1:0] buf_wdata_q, buf_wdata_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       pair_word;
  logic              pair_word_valid;
  logic              pair_drop;

  // Full compares the current registered wptr against the live read pointer.
  assign full = (wptr_q[ADDR_W-1:0] == rptr_in[ADDR_W-1:0]) &&
                (wptr_q[ADDR_W] != rptr_in[ADDR_W]);

  bsg_ds_byte_pair u_pair (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (io_valid_q),
    .byte_i       (io_data_q),
    .block_i      (full),
    .word_o       (pair_word),
    .word_valid_o (pair_word_valid),
    .drop_o       (pair_drop)
  );

  // Buffer write, pointer advance and sticky overflow.
  always_comb begin
    wptr_t_d    = wptr_q;
    buf_we_d    = pair_word_valid;
    overflow_d  = overflow_q | pair_drop;
    if (pair_word_valid) begin
      wptr_d      = wptr_q + {{ADDR_W{1'b0}}, 1'b1};
      buf_waddr_d = wptr_q[ADDR_W-1:0];
      buf_wdata_d = WORD_W'(pair_word);
    end else begin
      wptr_d      = wptr_q;
      buf_waddr_d = buf_waddr_q;
      buf_wdata_d = buf_wdata_q;
    end
  end

  // Input stage and write-side state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_valid_q  <= 1'b0;
      io_data_q   <= 8'h00;
      wptr_q      <= '0;
      wptr_t_q    <= '0;
      buf_we_q    <= 1'b0;
      buf_waddr_q <= '0;
      buf_wdata_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      io_valid_q  <= io_valid_in;
      io_data_q   <= io_data_in;
      wptr_q      <= wptr_d;
      wptr_t_q    <= wptr_t_d;
      buf_we_q    <= buf_we_d;
      buf_waddr_q <= buf_waddr_d;
      buf_wdata_q <= buf_wdata_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef BSG_DS_IO_WR_OVF_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  // Saturating count of dropped bytes.
  always_comb begin
    if (pair_drop && (ovf_cnt_q != 8'hFF)) begin
      ovf_cnt_d = ovf_cnt_q + 8'd1;
    end else begin
      ovf_cnt_d = ovf_cnt_q;
    end
  end

  // Dropped-byte counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt_q <= 8'h00;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

  assign io_valid  = io_valid_q;
  assign io_data   = io_data_q;
  assign wptr      = wptr_q;
  assign wptr_t    = wptr_t_q;
  assign buf_we    = buf_we_q;
  assign buf_waddr = buf_waddr_q;
  assign buf_wdata = buf_wdata_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_bsg_downstream_io_wr.sv
// Directed bench for bsg_downstream_io_wr with a write scoreboard.
module tb_bsg_downstream_io_wr;

  logic        clk = 1'b0;
  logic        rst;
  logic        io_valid_in;
  logic [7:0]  io_data_in;
  logic [6:0]  rptr_in;
  logic        buf_we;
  logic [5:0]  buf_waddr;
  logic [15:0] buf_wdata;
  logic [6:0]  wptr;
  logic [6:0]  wptr_t;
  logic        full;
  logic        io_valid;
  logic [7:0]  io_data;
  logic        overflow;
`ifdef BSG_DS_IO_WR_OVF_CNT_EN
  logic [7:0]  ovf_cnt;
`endif

  bsg_downstream_io_wr #(.ADDR_W(6), .WORD_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .io_valid_in (io_valid_in),
    .io_data_in  (io_data_in),
    .rptr_in     (rptr_in),
    .buf_we      (buf_we),
    .buf_waddr   (buf_waddr),
    .buf_wdata   (buf_wdata),
    .wptr        (wptr),
    .wptr_t      (wptr_t),
    .full        (full),
    .io_valid    (io_valid),
    .io_data     (io_data),
    .overflow    (overflow)
`ifdef BSG_DS_IO_WR_OVF_CNT_EN
    , .ovf_cnt   (ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t        sb_q[$];
  int         checks   = 0;
  int         failures = 0;
  logic [6:0] exp_wptr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    io_valid_in = 1'b1;
    io_data_in  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      io_valid_in = 1'b0;
    end
  endtask

  task automatic write_word(input logic [7:0] lo, input logic [7:0] hi);
    sb_q.push_back('{addr: exp_wptr[5:0], data: {hi, lo}});
    exp_wptr = exp_wptr + 7'd1;
    send_byte(lo);
    send_byte(hi);
  endtask

  // Write monitor: every buffer write must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (rst === 1'b0 && buf_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_write", {31'd0, buf_we}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("buf_waddr", {26'd0, buf_waddr}, {26'd0, e.addr});
        chk("buf_wdata", {16'd0, buf_wdata}, {16'd0, e.data});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    io_valid_in = 1'b0;
    io_data_in  = 8'h00;
    rptr_in     = 7'h00;
    exp_wptr    = 7'h00;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wptr",     {25'd0, wptr},     32'd0);
    chk("rst_wptr_t",   {25'd0, wptr_t},   32'd0);
    chk("rst_buf_we",   {31'd0, buf_we},   32'd0);
    chk("rst_io_valid", {31'd0, io_valid}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_full",     {31'd0, full},     32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic word: 0x34 then 0x12
    write_word(8'h34, 8'h12);
    idle(1);
    @(negedge clk);
    chk("io_data_reg",  {24'd0, io_data},  32'h12);
    chk("io_valid_reg", {31'd0, io_valid}, 32'd1);
    chk("we_not_early", {31'd0, buf_we},   32'd0);
    @(negedge clk);
    chk("we_pulse",     {31'd0, buf_we},   32'd1);
    chk("wptr_1",       {25'd0, wptr},     32'd1);
    chk("wptr_t_lag",   {25'd0, wptr_t},   32'd0);
    @(negedge clk);
    chk("we_one_cycle", {31'd0, buf_we},   32'd0);
    chk("wptr_t_1",     {25'd0, wptr_t},   32'd1);

    // Idle gap inside a word
    sb_q.push_back('{addr: exp_wptr[5:0], data: 16'hBBAA});
    exp_wptr = exp_wptr + 7'd1;
    send_byte(8'hAA);
    idle(3);
    send_byte(8'hBB);
    idle(4);
    chk("wptr_gap", {25'd0, wptr}, 32'd2);

    // Fill to full with rptr at 0, then drop a byte
    for (int i = 0; i < 62; i++) begin
      write_word(i[7:0], ~i[7:0]);
    end
    idle(4);
    chk("wptr_full",    {25'd0, wptr},     32'h40);
    chk("full_set",     {31'd0, full},     32'd1);
    chk("ovf_clear",    {31'd0, overflow}, 32'd0);
    send_byte(8'h99);
    idle(4);
    chk("ovf_set",      {31'd0, overflow}, 32'd1);
    chk("wptr_no_drop", {25'd0, wptr},     32'h40);
    rptr_in = 7'h01;
    #1;
    chk("full_live_rptr", {31'd0, full}, 32'd0);
    rptr_in = 7'h00;
    #1;
    chk("full_again", {31'd0, full}, 32'd1);
`ifdef BSG_DS_IO_WR_OVF_CNT_EN
    chk("ovf_cnt_1", {24'd0, ovf_cnt}, 32'd1);
    for (int i = 0; i < 300; i++) begin
      send_byte(i[7:0]);
    end
    idle(4);
    chk("ovf_cnt_sat", {24'd0, ovf_cnt}, 32'd255);
    idle(5);
    chk("ovf_cnt_hold", {24'd0, ovf_cnt}, 32'd255);
`endif

    // Advance to 0x7F and wrap
    rptr_in = 7'h40;
    for (int i = 0; i < 63; i++) begin
      write_word(8'hC0 ^ i[7:0], i[7:0]);
    end
    idle(4);
    chk("wptr_7f", {25'd0, wptr}, 32'h7F);
    rptr_in = 7'h7F;
    #1;
    chk("full_pre_wrap", {31'd0, full}, 32'd0);
    write_word(8'hEF, 8'hBE);
    idle(4);
    chk("wptr_wrap",      {25'd0, wptr}, 32'd0);
    chk("full_post_wrap", {31'd0, full}, 32'd0);

    // Reset in the middle of a word
    send_byte(8'h55);
    idle(2);
    rst = 1'b1;
    #1;
    chk("mid_rst_wptr",   {25'd0, wptr},     32'd0);
    chk("mid_rst_wptr_t", {25'd0, wptr_t},   32'd0);
    chk("mid_rst_ovf",    {31'd0, overflow}, 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    rptr_in  = 7'h00;
    exp_wptr = 7'h00;
    write_word(8'h01, 8'h02);
    idle(4);
    chk("post_rst_wptr", {25'd0, wptr}, 32'd1);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
